fc_engine_arbiter: RTL and testbench
====================================

Name: fc_engine_arbiter

Overview:
- Round-robin scheduler that shares one fully connected layer engine among NUM_REQ requesters, for example several network layers or several image tiles.
- Grants the engine to one requester at a time. Drives the engine's level start/done handshake and produces a one-hot select for the upstream activation/weight/bias muxes.
- Returns a per-requester completion pulse. A watchdog flags engine runs that take too long.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- TIMEOUT_CYCLES, 65535, maximum start-to-done cycle count before the watchdog flag is set.
- ID_WIDTH, $clog2(NUM_REQ), width of grant_id.
- CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the watchdog counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, active-low.
- req  input  NUM_REQ  level request per requester; held high until that requester's req_done.
- grant  output  NUM_REQ  one-hot current owner; all zero when no owner.
- grant_id  output  ID_WIDTH  binary index of the owner; drives the engine input muxes.
- busy  output  1  high while any grant is active.
- req_done  output  NUM_REQ  one-cycle completion pulse to the owner.
- req_out_valid  output  NUM_REQ  engine output_valid routed to the owner, combinationally: eng_output_valid & grant[i].
- eng_start  output  1  engine start, level.
- eng_done  input  1  engine done, level.
- eng_output_valid  input  1  engine output_valid pulse.
- clr_timeout  input  1  synchronous clear of timeout_flag.
- timeout_flag  output  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, active-low) sets:
  - state IDLE;
  - grant = 0, grant_id = 0, busy = 0;
  - req_done = 0, eng_start = 0;
  - timeout_flag = 0, watchdog counter = 0;
  - round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered except req_out_valid.
- Reset mid-run drops eng_start immediately. The engine shares rst_n and resets with the arbiter.
- States are IDLE, RUN and RELEASE.
- IDLE:
  - If any req bit is high, select the first set bit searching last+1, last+2, … with wrap modulo NUM_REQ.
  - On the next edge: grant ← one-hot(sel), grant_id ← sel, last ← sel, busy ← 1, eng_start ← 1, counter ← 0, go to RUN.
  - Latency from req high to grant/eng_start high is exactly 1 cycle.
  - With no req high, stay in IDLE and hold all outputs low.
- RUN:
  - eng_start is held high; the counter increments each cycle and saturates at TIMEOUT_CYCLES.
  - If eng_done = 1: on the next edge eng_start ← 0, req_done[grant_id] ← 1 for exactly one cycle, go to RELEASE.
  - If the counter reaches TIMEOUT_CYCLES first, timeout_flag ← 1 and the arbiter stays in RUN. The engine cannot be aborted, so there is no forced release.
- RELEASE:
  - eng_start stays low. The arbiter waits for eng_done = 0, i.e. the engine has returned to idle.
  - On that edge: grant ← 0, busy ← 0, go to IDLE.
  - The earliest next grant is the cycle after IDLE is entered. Back-to-back jobs therefore cost 2 idle cycles of engine start.
- Grant and grant_id are stable for the whole RUN and RELEASE interval. The engine may read its muxed inputs at any time during that interval.
- req changes while in RUN or RELEASE are ignored; arbitration is sampled only in IDLE.
- An owner dropping req early does not abort the run; req_done is still pulsed.
- A requester whose req stays high after req_done is eligible again, but only after every other pending requester is served (round-robin fairness).
- eng_done high while in IDLE (protocol error) is ignored.
- timeout_flag clears only on reset or clr_timeout = 1.
- If clr_timeout and a new timeout event occur in the same cycle, set wins.
- Watchdog counter width is CNT_WIDTH, unsigned; it never wraps.

Test Plan:
- Single requester (NUM_REQ=4): req = 0001 at cycle 0 → grant = 0001, grant_id = 0, eng_start = 1 at cycle 1. Engine model raises done at cycle 10 → req_done = 0001 pulses for cycle 11 only, eng_start = 0 from cycle 11, grant = 0 one cycle after the model drops done.
- Round-robin: req = 1111 held, each run 5 cycles → grant order is 0, 1, 2, 3, 0 with grant_id 0, 1, 2, 3, 0. No requester is granted twice in a row while others are pending.
- Wrap and priority: last = 2, req = 1011 → grant = 1000 (id 3). The next grant, with req = 0011, goes to id 0.
- Early drop: grant id 1, req[1] deasserted mid-RUN → the run continues, req_done[1] still pulses once, and the next IDLE ignores req[1].
- Watchdog (TIMEOUT_CYCLES=16): engine done withheld for 20 cycles → timeout_flag = 1 at cycle 17 after start, grant held. Done at cycle 20 completes normally with timeout_flag still 1. clr_timeout pulse → flag 0 next cycle.
- Reset mid-RUN: rst_n low during RUN → grant = 0, eng_start = 0, busy = 0 asynchronously. After release, req = 0100 → grant id 2 on the next cycle, since the pointer reset to 3 and the search starts at 0.

Source files
------------

// File: rtl/fc_engine_arbiter_if.sv
// Requester/engine handshake bundle for the FC engine arbiter.
// master = arbiter side, slave = requesters plus engine.
interface fc_engine_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] grant_id;
  logic                busy;
  logic [NUM_REQ-1:0]  req_done;
  logic [NUM_REQ-1:0]  req_out_valid;
  logic                eng_start;
  logic                eng_done;
  logic                eng_output_valid;
  logic                clr_timeout;
  logic                timeout_flag;

  modport master (
    input  req,
    input  eng_done,
    input  eng_output_valid,
    input  clr_timeout,
    output grant,
    output grant_id,
    output busy,
    output req_done,
    output req_out_valid,
    output eng_start,
    output timeout_flag
  );

  modport slave (
    output req,
    output eng_done,
    output eng_output_valid,
    output clr_timeout,
    input  grant,
    input  grant_id,
    input  busy,
    input  req_done,
    input  req_out_valid,
    input  eng_start,
    input  timeout_flag
  );
endinterface

// File: rtl/fc_engine_arbiter.sv
// Round-robin owner selection for one shared FC engine,
// with start/done sequencing and a sticky run watchdog.
module fc_engine_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int ID_WIDTH       = $clog2(NUM_REQ),
  parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES+1)
) (
  input logic                 clk,
  input logic                 rst_n,
  fc_engine_arbiter_if.master bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RELEASE
  } state_e;

  localparam logic [CNT_WIDTH-1:0] TMO =
    CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [ID_WIDTH-1:0] LAST_RST =
    ID_WIDTH'(NUM_REQ-1);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [ID_WIDTH-1:0] last_q, last_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                start_q, start_d;
  logic                tmo_q, tmo_d;
  logic [ID_WIDTH-1:0] sel;
  logic                found;
  logic                tmo_evt;
  int                  idx;

  // first pending requester after last, wrapping
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        sel   = ID_WIDTH'(idx);
      end
    end
  end

  assign tmo_evt = (state_q == RUN) && (cnt_q == TMO);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    start_d = start_q;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        id_d    = '0;
        busy_d  = 1'b0;
        start_d = 1'b0;
        cnt_d   = '0;
        if (found) begin
          grant_d[sel] = 1'b1;
          id_d    = sel;
          last_d  = sel;
          busy_d  = 1'b1;
          start_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q != TMO) cnt_d = cnt_q + 1'b1;
        if (bus.eng_done) begin
          start_d = 1'b0;
          done_d  = grant_q;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!bus.eng_done) begin
          grant_d = '0;
          id_d    = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // a fresh timeout event beats a same-cycle clear
  always_comb begin
    tmo_d = tmo_q;
    if (bus.clr_timeout) tmo_d = 1'b0;
    if (tmo_evt) tmo_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      id_q    <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_id      = id_q;
  assign bus.busy          = busy_q;
  assign bus.req_done      = done_q;
  assign bus.eng_start     = start_q;
  assign bus.timeout_flag  = tmo_q;
  assign bus.req_out_valid =
    {NUM_REQ{bus.eng_output_valid}} & grant_q;
endmodule

// File: tb/tb_fc_engine_arbiter.sv
// Directed vector bench for fc_engine_arbiter
// (NUM_REQ=4, TIMEOUT_CYCLES=16).
module tb_fc_engine_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fc_engine_arbiter_if #(.NUM_REQ(N)) bus ();

  fc_engine_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic       ov;
    logic [3:0] grant;
    logic [1:0] id;
    logic       busy;
    logic [3:0] rd;
    logic       start;
    logic [3:0] rov;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_out(input string t,
                         input logic [3:0] g,
                         input logic [1:0] id,
                         input logic b,
                         input logic [3:0] rd,
                         input logic s,
                         input logic [3:0] rov,
                         input logic tf);
    chk({t, ".grant"}, 32'(bus.grant), 32'(g));
    chk({t, ".id"}, 32'(bus.grant_id), 32'(id));
    chk({t, ".busy"}, 32'(bus.busy), 32'(b));
    chk({t, ".done"}, 32'(bus.req_done), 32'(rd));
    chk({t, ".start"}, 32'(bus.eng_start), 32'(s));
    chk({t, ".rov"}, 32'(bus.req_out_valid), 32'(rov));
    chk({t, ".tmo"}, 32'(bus.timeout_flag), 32'(tf));
  endtask

  task automatic step(input logic [3:0] r,
                      input logic d,
                      input logic ov,
                      input logic c);
    @(negedge clk);
    bus.req = r;
    bus.eng_done = d;
    bus.eng_output_valid = ov;
    bus.clr_timeout = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = '0;
    bus.eng_done = 1'b0;
    bus.eng_output_valid = 1'b0;
    bus.clr_timeout = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // single job, then walk the pointer to 2 and wrap
    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0000};
    tbl[1]  = '{4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001};
    tbl[2]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0000};
    tbl[3]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0001, 1'b0, 4'b0000};
    tbl[4]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0, 4'b0000};
    tbl[5]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 4'b0000};
    tbl[6]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 4'b0000};
    tbl[7]  = '{4'b0110, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0000};
    tbl[8]  = '{4'b0110, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0010, 1'b0, 4'b0000};
    tbl[9]  = '{4'b0110, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 4'b0000};
    tbl[10] = '{4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0000};
    tbl[11] = '{4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b0, 4'b0000};
    tbl[12] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 4'b0000};
    tbl[13] = '{4'b1011, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b0000};
    tbl[14] = '{4'b1011, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1, 4'b1000, 1'b0, 4'b0000};
    tbl[15] = '{4'b1011, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 4'b0000};
    tbl[16] = '{4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0000};
    tbl[17] = '{4'b0011, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0001, 1'b0, 4'b0000};
    tbl[18] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 4'b0000};

    do_reset();
    #1;
    chk_out("reset", 4'b0, 2'd0, 1'b0, 4'b0,
            1'b0, 4'b0, 1'b0);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].req, tbl[i].done, tbl[i].ov, 1'b0);
      chk_out($sformatf("vec%0d", i),
              tbl[i].grant, tbl[i].id, tbl[i].busy,
              tbl[i].rd, tbl[i].start, tbl[i].rov,
              1'b0);
    end

    // round robin with all four pending
    do_reset();
    for (int j = 0; j < 5; j++) begin
      step(4'b1111, 1'b0, 1'b0, 1'b0);
      chk_out($sformatf("rr%0d.gnt", j),
              4'(4'b0001 << (j % 4)), 2'(j % 4),
              1'b1, 4'b0, 1'b1, 4'b0, 1'b0);
      repeat (3) step(4'b1111, 1'b0, 1'b0, 1'b0);
      step(4'b1111, 1'b1, 1'b0, 1'b0);
      chk($sformatf("rr%0d.done", j),
          32'(bus.req_done), 32'(4'b0001 << (j % 4)));
      step(4'b1111, 1'b0, 1'b0, 1'b0);
      chk($sformatf("rr%0d.rel", j),
          32'(bus.grant), 32'd0);
    end

    // owner drops req mid-run
    step(4'b0010, 1'b0, 1'b0, 1'b0);
    chk_out("drop.gnt", 4'b0010, 2'd1, 1'b1,
            4'b0, 1'b1, 4'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk_out("drop.run", 4'b0010, 2'd1, 1'b1,
            4'b0, 1'b1, 4'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("drop.done", 32'(bus.req_done), 32'h2);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk_out("drop.rel", 4'b0, 2'd0, 1'b0,
            4'b0, 1'b0, 4'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk_out("drop.idle", 4'b0, 2'd0, 1'b0,
            4'b0, 1'b0, 4'b0, 1'b0);

    // watchdog: done withheld for 20 cycles
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    chk("wd.gnt", 32'(bus.grant_id), 32'd2);
    for (int j = 1; j < 20; j++) begin
      step(4'b0100, 1'b0, 1'b0, 1'b0);
      chk($sformatf("wd.tmo%0d", j),
          32'(bus.timeout_flag), 32'(j >= 17));
      chk($sformatf("wd.hold%0d", j),
          32'(bus.grant), 32'h4);
    end
    step(4'b0100, 1'b1, 1'b0, 1'b0);
    chk_out("wd.done", 4'b0100, 2'd2, 1'b1,
            4'b0100, 1'b0, 4'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk_out("wd.rel", 4'b0, 2'd0, 1'b0,
            4'b0, 1'b0, 4'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("wd.clr", 32'(bus.timeout_flag), 32'd0);

    // asynchronous reset in the middle of a run
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    chk("rst.gnt", 32'(bus.grant), 32'h1);
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst.async", 4'b0, 2'd0, 1'b0,
            4'b0, 1'b0, 4'b0, 1'b0);
    bus.req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    chk_out("rst.regnt", 4'b0100, 2'd2, 1'b1,
            4'b0, 1'b1, 4'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
